axis_frame_fifo_arbiter: RTL and testbench
==========================================

# axis_frame_fifo_arbiter

Frame-granular round-robin arbiter that shares one `axis_frame_fifo` write port between `PORTS` AXI-stream sources. A grant is held from the first beat of a frame through its `tlast` beat, so frames are never interleaved in the FIFO. The block also attributes and counts frames the FIFO drops (its `drop_frame` output). It sits directly upstream of the frame FIFO input.

## Interface
- `PORTS`, 4, number of requesting sources (2..8).
- `DATA_WIDTH`, 8, tdata width per source.
- `TIMEOUT`, 16, stall cycles before the watchdog aborts a frame (watchdog build only).
- `clk` input 1: clock, all logic rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `input_axis_tdata` input PORTS*DATA_WIDTH: packed source data, port i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `input_axis_tvalid` input PORTS: per-source valid.
- `input_axis_tready` output PORTS: per-source ready.
- `input_axis_tlast` input PORTS: per-source end of frame.
- `input_axis_tuser` input PORTS: per-source bad-frame flag.
- `output_axis_tdata` output DATA_WIDTH: to FIFO `input_axis_tdata`.
- `output_axis_tvalid` output 1: to FIFO.
- `output_axis_tready` input 1: from FIFO.
- `output_axis_tlast` output 1: to FIFO.
- `output_axis_tuser` output 1: to FIFO.
- `fifo_drop_frame` input 1: FIFO `drop_frame` pulse.
- `grant_valid` output 1: a frame is in progress.
- `grant_index` output $clog2(PORTS): granted source.
- `drop_count` output 16: saturating count of dropped frames.
- `drop_port` output $clog2(PORTS): source of the most recent drop.

## Operation
- FSM states: IDLE, ARB, ACTIVE, plus ABORT in watchdog builds.
- IDLE: when any `input_axis_tvalid` bit is set, go to ARB.
- ARB (one cycle): register the first requester found searching from `last_grant+1` upward, with modulo-PORTS wrap. Set `grant_index` and `grant_valid`=1, then go to ACTIVE. If no requester remains (valid withdrawn), return to IDLE.
- ACTIVE, combinational pass-through from the granted source g:
  - `output_axis_*` = source g signals.
  - `input_axis_tready[g]` = `output_axis_tready`.
  - All other `input_axis_tready` bits are 0.
- In any state other than ACTIVE, every `input_axis_tready` bit is 0 and `output_axis_tvalid` = 0.
- Frame end: a transfer (valid & ready) with `tlast`=1 sets `last_grant`=g and `grant_valid`=0, and moves to IDLE.
- Fairness: a source that keeps requesting is re-granted only after every other requesting source has had one frame.
- Drop accounting: each cycle with `fifo_drop_frame`=1 while `grant_valid`=1 is handled as follows.
  - `drop_port` loads `grant_index`.
  - `drop_count` increments, saturating at 16'hFFFF.
  - A drop pulse is counted at most once per frame; further pulses within the same grant are ignored.
  - Pulses while `grant_valid`=0 are ignored.
- Reset values: FSM=IDLE, `last_grant`=PORTS-1 (first grant goes to port 0), `grant_valid`=0, `grant_index`=0, `drop_count`=0, `drop_port`=0, all tready 0, `output_axis_tvalid`=0.
- Reset mid-frame: the grant is abandoned immediately. The FIFO is responsible for discarding the partial frame (it shares the reset domain).

## Timing
- Arbitration latency: a request in IDLE is first granted 2 cycles later (IDLE→ARB→ACTIVE).
- Minimum frame-to-frame gap: 2 idle cycles on the output after a `tlast` transfer.
- Data path in ACTIVE is zero-latency combinational: ready and valid pass through with no registers.
- `drop_count` and `drop_port` update on the clock edge after the `fifo_drop_frame` cycle.
- Simultaneous `tlast` transfer and `fifo_drop_frame`: the drop is attributed to the finishing grant.

## Configuration
- `ARB_WATCHDOG_EN` defined:
  - In ACTIVE, a counter tracks consecutive cycles with `input_axis_tvalid[g]`=0; it resets on any valid beat.
  - When the counter reaches `TIMEOUT`, go to ABORT.
  - ABORT drives `output_axis_tvalid`=1, `tlast`=1, `tuser`=1, `tdata`=0, with all `input_axis_tready`=0, until `output_axis_tready`=1.
  - The FSM then goes to IDLE, `last_grant` is set to g, and the remainder of the source frame competes as a new frame.
- `ARB_WATCHDOG_EN` undefined: no counter and no ABORT state. A stalled source holds the grant indefinitely.

## Test plan
- Single source: port 0 sends 3 beats (1,2,3, tlast on 3) with `output_axis_tready`=1 → `grant_index`=0 from cycle 2; output shows 1,2,3 with tlast on 3; `grant_valid` falls after the tlast transfer.
- Round robin: ports 0 and 2 both send continuous 1-beat frames → grants alternate 0,2,0,2; port 1 never sees `tready`=1.
- Backpressure: hold `output_axis_tready`=0 for 4 cycles mid-frame → granted tready is 0 for those cycles, and no other port is granted before tlast.
- Drop count: two `fifo_drop_frame` pulses within one port-3 frame → `drop_count`=1 and `drop_port`=3; preload the counter at 16'hFFFF and drop again → it stays at FFFF.
- Reset: assert `rst_n`=0 mid-frame on port 1 → outputs take their reset values asynchronously; after release, the first grant goes to port 0.
- Watchdog (`ARB_WATCHDOG_EN`, TIMEOUT=16): port 0 sends 1 beat without tlast and then drops valid → after 16 stall cycles the output carries tdata=0 with tlast=1 and tuser=1, then returns to IDLE.

Source files
------------

// File: rtl/axis_frame_fifo_arbiter.sv
// axis_frame_fifo_arbiter
// Frame-granular round-robin arbiter feeding one axis_frame_fifo write port.
// A grant is held from the first beat of a frame to its tlast beat, so frames
// from different sources never interleave. FIFO drop_frame pulses are
// attributed to the granted source and counted once per frame (saturating).
//
// Optional build macro: ARB_WATCHDOG_EN adds a stall watchdog that closes a
// frame whose source stops sending (ABORT drives a tlast/tuser beat).
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no grant; wait for any source tvalid
// ARB     | one cycle: pick next requester after last_grant (round robin)
// ACTIVE  | granted source passed through combinationally to the FIFO
// ABORT   | watchdog build only: emit tdata=0/tlast/tuser beat, then IDLE

module axis_frame_fifo_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0]   input_axis_tdata,
  input  logic [PORTS-1:0]              input_axis_tvalid,
  output logic [PORTS-1:0]              input_axis_tready,
  input  logic [PORTS-1:0]              input_axis_tlast,
  input  logic [PORTS-1:0]              input_axis_tuser,
  output logic [DATA_WIDTH-1:0]         output_axis_tdata,
  output logic                          output_axis_tvalid,
  input  logic                          output_axis_tready,
  output logic                          output_axis_tlast,
  output logic                          output_axis_tuser,
  input  logic                          fifo_drop_frame,
  output logic                          grant_valid,
  output logic [$clog2(PORTS)-1:0]      grant_index,
  output logic [15:0]                   drop_count,
  output logic [$clog2(PORTS)-1:0]      drop_port
);

  localparam int IW = $clog2(PORTS);

`ifdef ARB_WATCHDOG_EN
  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_ACTIVE, ST_ABORT} state_t;
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] r_wd_cnt;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_ACTIVE} state_t;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IW-1:0]         r_last_grant;
  logic [IW-1:0]         r_grant_index;
  logic                  r_grant_valid;
  logic                  r_dropped;
  logic [15:0]           r_drop_count;
  logic [IW-1:0]         r_drop_port;

  logic                  w_found;
  logic [IW-1:0]         w_pick;
  logic [IW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_src_data;
  logic                  w_src_valid;
  logic                  w_src_last;
  logic                  w_src_user;
  logic                  w_grant_load;
  logic                  w_frame_end;

  // Round-robin search: first requester starting at last_grant+1, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= PORTS; k++) begin
      w_idx = IW'((int'(r_last_grant) + k) % PORTS);
      if (!w_found && input_axis_tvalid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Select the granted source's stream signals.
  always_comb begin
    w_src_data  = input_axis_tdata[int'(r_grant_index)*DATA_WIDTH +: DATA_WIDTH];
    w_src_valid = input_axis_tvalid[r_grant_index];
    w_src_last  = input_axis_tlast[r_grant_index];
    w_src_user  = input_axis_tuser[r_grant_index];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and data-path outputs; only ACTIVE opens the pass-through.
  always_comb begin
    w_state_nxt        = r_state;
    input_axis_tready  = '0;
    output_axis_tdata  = '0;
    output_axis_tvalid = 1'b0;
    output_axis_tlast  = 1'b0;
    output_axis_tuser  = 1'b0;
    w_grant_load       = 1'b0;
    w_frame_end        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|input_axis_tvalid) w_state_nxt = ST_ARB;
      end
      ST_ARB: begin
        if (w_found) begin
          w_state_nxt  = ST_ACTIVE;
          w_grant_load = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        output_axis_tdata                = w_src_data;
        output_axis_tvalid               = w_src_valid;
        output_axis_tlast                = w_src_last;
        output_axis_tuser                = w_src_user;
        input_axis_tready[r_grant_index] = output_axis_tready;
        if (w_src_valid && output_axis_tready && w_src_last) begin
          w_state_nxt = ST_IDLE;
          w_frame_end = 1'b1;
        end
`ifdef ARB_WATCHDOG_EN
        else if (!w_src_valid && (r_wd_cnt == '0)) begin
          w_state_nxt = ST_ABORT;
        end
`endif
      end
`ifdef ARB_WATCHDOG_EN
      ST_ABORT: begin
        output_axis_tvalid = 1'b1;
        output_axis_tlast  = 1'b1;
        output_axis_tuser  = 1'b1;
        if (output_axis_tready) begin
          w_state_nxt = ST_IDLE;
          w_frame_end = 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant bookkeeping: load on arbitration, release and remember at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_valid <= 1'b0;
      r_grant_index <= '0;
      r_last_grant  <= IW'(PORTS - 1);
    end else if (w_grant_load) begin
      r_grant_valid <= 1'b1;
      r_grant_index <= w_pick;
    end else if (w_frame_end) begin
      r_grant_valid <= 1'b0;
      r_last_grant  <= r_grant_index;
    end
  end

  // Drop attribution: first drop pulse of each grant counts, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dropped    <= 1'b0;
      r_drop_count <= '0;
      r_drop_port  <= '0;
    end else if (w_grant_load) begin
      r_dropped <= 1'b0;
    end else if (fifo_drop_frame && r_grant_valid && !r_dropped) begin
      r_dropped   <= 1'b1;
      r_drop_port <= r_grant_index;
      if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

`ifdef ARB_WATCHDOG_EN
  // Stall watchdog: down-counter reloaded on grant and on every source beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= WW'(TIMEOUT - 1);
    end else if (w_grant_load || ((r_state == ST_ACTIVE) && w_src_valid)) begin
      r_wd_cnt <= WW'(TIMEOUT - 1);
    end else if ((r_state == ST_ACTIVE) && (r_wd_cnt != '0)) begin
      r_wd_cnt <= r_wd_cnt - WW'(1);
    end
  end
`endif

  assign grant_valid = r_grant_valid;
  assign grant_index = r_grant_index;
  assign drop_count  = r_drop_count;
  assign drop_port   = r_drop_port;

endmodule

// File: tb/tb_axis_frame_fifo_arbiter.sv
// Directed bench for axis_frame_fifo_arbiter (PORTS=4, DATA_WIDTH=8).
// Inputs change on the falling edge; outputs are checked #1 later.
module tb_axis_frame_fifo_arbiter;

  localparam int P  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [P*DW-1:0] in_data;
  logic [P-1:0]    in_valid;
  logic [P-1:0]    in_ready;
  logic [P-1:0]    in_last;
  logic [P-1:0]    in_user;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            out_user;
  logic            fifo_drop;
  logic            grant_valid;
  logic [1:0]      grant_index;
  logic [15:0]     drop_count;
  logic [1:0]      drop_port;

  int total = 0;
  int bad   = 0;
  int cyc;

  axis_frame_fifo_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .input_axis_tdata   (in_data),
    .input_axis_tvalid  (in_valid),
    .input_axis_tready  (in_ready),
    .input_axis_tlast   (in_last),
    .input_axis_tuser   (in_user),
    .output_axis_tdata  (out_data),
    .output_axis_tvalid (out_valid),
    .output_axis_tready (out_ready),
    .output_axis_tlast  (out_last),
    .output_axis_tuser  (out_user),
    .fifo_drop_frame    (fifo_drop),
    .grant_valid        (grant_valid),
    .grant_index        (grant_index),
    .drop_count         (drop_count),
    .drop_port          (drop_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input logic [1:0] p, input logic [7:0] d, input logic v, input logic l);
    in_data[int'(p)*DW +: DW] = d;
    in_valid[p]               = v;
    in_last[p]                = l;
    in_user[p]                = 1'b0;
  endtask

  // Step falling edges until a grant is visible (bounded), then check it.
  task automatic wait_grant(input string tag, input logic [1:0] exp_idx, output int n);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (grant_valid !== 1'b1 && n < 10);
    chk({tag, "_gv"}, 32'(grant_valid), 32'd1);
    chk({tag, "_idx"}, 32'(grant_index), 32'(exp_idx));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    in_last   = '0;
    in_user   = '0;
    out_ready = 1'b1;
    fifo_drop = 1'b0;
    #1;
    chk("rst_gv",    32'(grant_valid), 32'd0);
    chk("rst_idx",   32'(grant_index), 32'd0);
    chk("rst_dcnt",  32'(drop_count),  32'd0);
    chk("rst_dport", 32'(drop_port),   32'd0);
    chk("rst_rdy",   32'(in_ready),    32'd0);
    chk("rst_oval",  32'(out_valid),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single source, 3 beats on port 0
    @(negedge clk);
    set_src(2'd0, 8'd1, 1'b1, 1'b0);
    #1;
    chk("ss_idle_rdy",  32'(in_ready),  32'd0);
    chk("ss_idle_oval", 32'(out_valid), 32'd0);
    wait_grant("ss", 2'd0, cyc);
    chk("ss_lat",   32'(cyc),      32'd2);
    chk("ss_d1",    32'(out_data), 32'd1);
    chk("ss_rdy0",  32'(in_ready), 32'b0001);
    chk("ss_last1", 32'(out_last), 32'd0);
    @(negedge clk);
    set_src(2'd0, 8'd2, 1'b1, 1'b0);
    #1;
    chk("ss_d2", 32'(out_data), 32'd2);
    @(negedge clk);
    set_src(2'd0, 8'd3, 1'b1, 1'b1);
    #1;
    chk("ss_d3",    32'(out_data), 32'd3);
    chk("ss_last3", 32'(out_last), 32'd1);
    @(negedge clk);
    set_src(2'd0, 8'd0, 1'b0, 1'b0);
    #1;
    chk("ss_end_gv",   32'(grant_valid), 32'd0);
    chk("ss_end_oval", 32'(out_valid),   32'd0);

    // Round robin between ports 0 and 2 (last grant was 0, so 2 goes first)
    @(negedge clk);
    set_src(2'd0, 8'hA0, 1'b1, 1'b1);
    set_src(2'd2, 8'hC2, 1'b1, 1'b1);
    for (int f = 0; f < 4; f++) begin
      logic [1:0] e;
      e = (f % 2 == 0) ? 2'd2 : 2'd0;
      wait_grant("rr", e, cyc);
      chk("rr_gap",  32'(cyc),         (f == 0) ? 32'd2 : 32'd3);
      chk("rr_data", 32'(out_data),    (e == 2'd2) ? 32'hC2 : 32'hA0);
      chk("rr_rdy1", 32'(in_ready[1]), 32'd0);
      chk("rr_rdyg", 32'(in_ready[e]), 32'd1);
    end
    @(negedge clk);
    in_valid = '0;
    in_last  = '0;

    // Backpressure on a port-3 frame while port 1 waits
    @(negedge clk);
    set_src(2'd3, 8'h31, 1'b1, 1'b0);
    wait_grant("bp", 2'd3, cyc);
    out_ready = 1'b0;
    set_src(2'd1, 8'h11, 1'b1, 1'b1);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      chk("bp_rdy",  32'(in_ready),    32'd0);
      chk("bp_idx",  32'(grant_index), 32'd3);
      chk("bp_oval", 32'(out_valid),   32'd1);
      chk("bp_data", 32'(out_data),    32'h31);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy3", 32'(in_ready), 32'b1000);
    @(negedge clk);
    set_src(2'd3, 8'h32, 1'b1, 1'b0);
    @(negedge clk);
    set_src(2'd3, 8'h33, 1'b1, 1'b1);
    #1;
    chk("bp_idx_end", 32'(grant_index), 32'd3);
    chk("bp_last",    32'(out_last),    32'd1);
    chk("bp_d3",      32'(out_data),    32'h33);
    @(negedge clk);
    set_src(2'd3, 8'h00, 1'b0, 1'b0);
    wait_grant("bp_p1", 2'd1, cyc);
    chk("bp_p1_data", 32'(out_data), 32'h11);
    @(negedge clk);
    in_valid = '0;
    in_last  = '0;

    // Drop accounting: two pulses in one port-3 frame count once
    @(negedge clk);
    set_src(2'd3, 8'h41, 1'b1, 1'b0);
    wait_grant("dr", 2'd3, cyc);
    fifo_drop = 1'b1;
    @(negedge clk);
    set_src(2'd3, 8'h42, 1'b1, 1'b0);
    #1;
    chk("dr_cnt1",  32'(drop_count), 32'd1);
    chk("dr_port3", 32'(drop_port),  32'd3);
    @(negedge clk);
    fifo_drop = 1'b0;
    set_src(2'd3, 8'h43, 1'b1, 1'b1);
    #1;
    chk("dr_cnt_once", 32'(drop_count), 32'd1);
    @(negedge clk);
    set_src(2'd3, 8'h00, 1'b0, 1'b0);
    fifo_drop = 1'b1;
    #1;
    chk("dr_idle_gv", 32'(grant_valid), 32'd0);
    @(negedge clk);
    fifo_drop = 1'b0;
    #1;
    chk("dr_idle_ign", 32'(drop_count), 32'd1);

    // Saturation, with the drop coinciding with a tlast transfer on port 0
    force dut.r_drop_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_drop_count;
    #1;
    chk("sat_pre", 32'(drop_count), 32'hFFFF);
    set_src(2'd0, 8'hB0, 1'b1, 1'b1);
    wait_grant("sat", 2'd0, cyc);
    fifo_drop = 1'b1;
    @(negedge clk);
    fifo_drop = 1'b0;
    set_src(2'd0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("sat_cnt",  32'(drop_count),  32'hFFFF);
    chk("sat_port", 32'(drop_port),   32'd0);
    chk("sat_gv",   32'(grant_valid), 32'd0);

    // Reset in the middle of a port-1 frame
    @(negedge clk);
    set_src(2'd1, 8'h61, 1'b1, 1'b0);
    wait_grant("rs", 2'd1, cyc);
    rst_n = 1'b0;
    #1;
    chk("rs_gv",    32'(grant_valid), 32'd0);
    chk("rs_idx",   32'(grant_index), 32'd0);
    chk("rs_dcnt",  32'(drop_count),  32'd0);
    chk("rs_dport", 32'(drop_port),   32'd0);
    chk("rs_rdy",   32'(in_ready),    32'd0);
    chk("rs_oval",  32'(out_valid),   32'd0);
    set_src(2'd0, 8'h70, 1'b1, 1'b1);
    set_src(2'd1, 8'h61, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant("rs_p0", 2'd0, cyc);
    chk("rs_lat",  32'(cyc),      32'd2);
    chk("rs_d0",   32'(out_data), 32'h70);
    wait_grant("rs_p1", 2'd1, cyc);
    chk("rs_d1",   32'(out_data), 32'h61);
    @(negedge clk);
    in_valid = '0;
    in_last  = '0;

`ifdef ARB_WATCHDOG_EN
    // Watchdog: port 0 sends one beat without tlast, then stalls
    @(negedge clk);
    set_src(2'd0, 8'h55, 1'b1, 1'b0);
    wait_grant("wd", 2'd0, cyc);
    @(negedge clk);
    set_src(2'd0, 8'h00, 1'b0, 1'b0);
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (out_valid !== 1'b1 && cyc < 24);
    chk("wd_stall", 32'(cyc),      32'd16);
    chk("wd_data",  32'(out_data), 32'd0);
    chk("wd_last",  32'(out_last), 32'd1);
    chk("wd_user",  32'(out_user), 32'd1);
    chk("wd_rdy",   32'(in_ready), 32'd0);
    @(negedge clk); #1;
    chk("wd_gv",   32'(grant_valid), 32'd0);
    chk("wd_oval", 32'(out_valid),   32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
